// File: rtl/car_leave_checkout_if.sv
// Checkout-side UI bus: buttons/keypad/view and entry events in,
// occupancy, cursor, fee and release status out.
interface car_leave_checkout_if;
  logic [4:0]  bt_out;
  logic [2:0]  view;
  logic [15:0] key_out;
  logic        enter_valid;
  logic [2:0]  enter_slot;
  logic [7:0]  occupied;
  logic [2:0]  cursor;
  logic [7:0]  fee;
  logic        leave_pulse;
  logic [2:0]  leave_slot;
  logic [2:0]  state;

  modport master (
    output bt_out, view, key_out, enter_valid, enter_slot,
    input  occupied, cursor, fee, leave_pulse, leave_slot, state
  );
  modport slave (
    input  bt_out, view, key_out, enter_valid, enter_slot,
    output occupied, cursor, fee, leave_pulse, leave_slot, state
  );
endinterface

// File: rtl/car_leave_checkout.sv
// Exit-side slot tracker: per-slot occupancy/parking-time counters plus
// the select/bill/paid checkout FSM driven from the shared UI bus.
module car_slot_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_enter,
  input  logic       i_release,
  output logic       o_occ,
  output logic [7:0] o_units
);
  logic       r_occ;
  logic [7:0] r_units;

  // Release beats a coincident entry on the same slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ   <= 1'b0;
      r_units <= 8'd0;
    end else if (i_release) begin
      r_occ   <= 1'b0;
      r_units <= 8'd0;
    end else if (i_enter && !r_occ) begin
      r_occ   <= 1'b1;
      r_units <= 8'd0;
    end else if (i_tick && r_occ && r_units != 8'hFF) begin
      r_units <= r_units + 8'd1;
    end
  end

  assign o_occ   = r_occ;
  assign o_units = r_units;
endmodule

module car_leave_checkout #(
  parameter int N_SLOTS     = 8,
  parameter int CLK_DIV     = 100000000,
  parameter int RATE        = 5,
  parameter int PAID_CYCLES = 200000000
) (
  input logic                 clk,
  input logic                 rst,
  car_leave_checkout_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd1, S_SELECT = 3'd2, S_BILL = 3'd3, S_PAID = 3'd4
  } state_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (PAID_CYCLES > 1) ? $clog2(PAID_CYCLES) : 1;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cursor, w_cursor_nxt;
  logic [7:0]        r_fee, w_fee_nxt;
  logic              r_latch;
  logic [PW-1:0]     r_presc;
  logic [TW-1:0]     r_paid_cnt;
  logic              r_leave_pulse;
  logic [2:0]        r_leave_slot;

  logic [N_SLOTS-1:0]          w_occ;
  logic [N_SLOTS-1:0][7:0]     w_units;
  logic              w_act, w_btn_any, w_take, w_mid, w_left, w_right;
  logic [7:0]        w_keys;
  logic              w_key_hit, w_tick, w_release, w_paid_done;
  logic [7:0]        w_u1;
  logic [15:0]       w_bill;
  logic [7:0]        w_fee_calc;
  logic              w_unused;

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    f_lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) f_lowest = 3'(i);
  endfunction

  // Nearest occupied slot in the given direction, wrapping; unchanged if none.
  function automatic logic [2:0] f_step(input logic [7:0] occ, input logic [2:0] cur,
                                        input logic up);
    logic [2:0] idx;
    logic       found;
    f_step = cur;
    found  = 1'b0;
    for (int k = 1; k < 8; k++) begin
      idx = up ? cur + 3'(k) : cur - 3'(k);
      if (!found && occ[idx]) begin
        f_step = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign w_act     = (bus.view == 3'd1);
  assign w_btn_any = bus.bt_out[3] | bus.bt_out[1] | bus.bt_out[0];
  assign w_take    = w_btn_any && !r_latch && w_act;
  assign w_mid     = w_take && bus.bt_out[3];
  assign w_left    = w_take && !bus.bt_out[3] && bus.bt_out[1];
  assign w_right   = w_take && !bus.bt_out[3] && !bus.bt_out[1] && bus.bt_out[0];
  assign w_keys    = bus.key_out[7:0] & w_occ;
  assign w_key_hit = w_act && (|w_keys);
  assign w_tick    = (r_presc == PW'(CLK_DIV - 1));
  assign w_release = (r_state == S_BILL) && w_mid;
  assign w_paid_done = (r_paid_cnt == TW'(PAID_CYCLES - 1));
  assign w_unused  = ^{bus.bt_out[4], bus.bt_out[2], bus.key_out[15:8]};

  // Fee uses at least one started unit and saturates at 8 bits.
  assign w_u1       = (w_units[r_cursor] == 8'd0) ? 8'd1 : w_units[r_cursor];
  assign w_bill     = {8'd0, w_u1} * 16'(RATE);
  assign w_fee_calc = (w_bill > 16'd255) ? 8'd255 : w_bill[7:0];

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    car_slot_timer u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_enter  (bus.enter_valid && bus.enter_slot == 3'(g)),
      .i_release(w_release && r_cursor == 3'(g)),
      .o_occ    (w_occ[g]),
      .o_units  (w_units[g])
    );
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_fee_nxt    = r_fee;
    case (r_state)
      S_IDLE:
        if (w_mid && |w_occ) begin
          w_state_nxt  = S_SELECT;
          w_cursor_nxt = f_lowest(w_occ);
        end
      S_SELECT:
        if (!w_occ[r_cursor])  w_state_nxt = S_IDLE;
        else if (w_mid) begin
          w_state_nxt = S_BILL;
          w_fee_nxt   = w_fee_calc;
        end
        else if (w_left)       w_cursor_nxt = f_step(w_occ, r_cursor, 1'b0);
        else if (w_right)      w_cursor_nxt = f_step(w_occ, r_cursor, 1'b1);
        else if (w_key_hit)    w_cursor_nxt = f_lowest(w_keys);
      S_BILL:
        if (w_mid)             w_state_nxt = S_PAID;
        else if (w_left)       w_state_nxt = S_SELECT;
      S_PAID:
        if (w_mid || w_paid_done) begin
          w_state_nxt = S_IDLE;
          w_fee_nxt   = 8'd0;
        end
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cursor      <= 3'd0;
      r_fee         <= 8'd0;
      r_latch       <= 1'b0;
      r_presc       <= '0;
      r_paid_cnt    <= '0;
      r_leave_pulse <= 1'b0;
      r_leave_slot  <= 3'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cursor      <= w_cursor_nxt;
      r_fee         <= w_fee_nxt;
      r_latch       <= w_btn_any;
      r_presc       <= w_tick ? '0 : r_presc + PW'(1);
      r_paid_cnt    <= (r_state == S_PAID) ? r_paid_cnt + TW'(1) : '0;
      r_leave_pulse <= w_release;
      if (w_release) r_leave_slot <= r_cursor;
    end
  end

  assign bus.occupied    = w_occ;
  assign bus.cursor      = r_cursor;
  assign bus.fee         = r_fee;
  assign bus.leave_pulse = r_leave_pulse;
  assign bus.leave_slot  = r_leave_slot;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_car_leave_checkout.sv
// Directed bench for car_leave_checkout with a cycle-level reference model.
module tb_car_leave_checkout;
  localparam int CLK_DIV = 4;
  localparam int RATE = 5;
  localparam int PAID_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  car_leave_checkout_if bus ();

  car_leave_checkout #(
    .N_SLOTS(8), .CLK_DIV(CLK_DIV), .RATE(RATE), .PAID_CYCLES(PAID_CYCLES)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: plain integers, slot arrays, linear searches.
  int       m_state, m_cur, m_fee, m_presc, m_paid, m_ls;
  bit       m_latch, m_lp;
  bit [7:0] m_occ;
  int       m_cnt [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int fee_of(input int u);
    int f;
    f = ((u < 1) ? 1 : u) * RATE;
    return (f > 255) ? 255 : f;
  endfunction

  function automatic int walk(input bit [7:0] occ, input int cur, input int dir);
    for (int s = 1; s < 8; s++) begin
      int idx;
      idx = (cur + dir * s + 8) % 8;
      if (occ[idx]) return idx;
    end
    return cur;
  endfunction

  always @(posedge clk) begin
    bit m, l, r, any, take, tm, tl, tr, tick, rel, found;
    int nst, ncur, nfee;
    if (!rst) begin
      m_state = 1; m_cur = 0; m_fee = 0; m_presc = 0; m_paid = 0;
      m_ls = 0; m_latch = 0; m_lp = 0; m_occ = '0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      m = bus.bt_out[3]; l = bus.bt_out[1]; r = bus.bt_out[0];
      any  = m | l | r;
      take = any && !m_latch && (bus.view == 3'd1);
      tm = take && m; tl = take && !m && l; tr = take && !m && !l && r;
      m_latch = any;
      tick = (m_presc == CLK_DIV - 1);
      m_presc = tick ? 0 : m_presc + 1;
      rel = (m_state == 3) && tm;
      nst = m_state; ncur = m_cur; nfee = m_fee;
      case (m_state)
        1: if (tm && m_occ != 0) begin
             nst = 2;
             found = 0;
             for (int i = 0; i < 8; i++)
               if (!found && m_occ[i]) begin ncur = i; found = 1; end
           end
        2: if (!m_occ[m_cur]) nst = 1;
           else if (tm) begin nst = 3; nfee = fee_of(m_cnt[m_cur]); end
           else if (tl) ncur = walk(m_occ, m_cur, -1);
           else if (tr) ncur = walk(m_occ, m_cur, 1);
           else if (bus.view == 3'd1) begin
             found = 0;
             for (int i = 0; i < 8; i++)
               if (!found && bus.key_out[i] && m_occ[i]) begin ncur = i; found = 1; end
           end
        3: if (tm) nst = 4; else if (tl) nst = 2;
        4: begin
             m_paid++;
             if (tm || m_paid == PAID_CYCLES) begin nst = 1; nfee = 0; end
           end
        default: nst = 1;
      endcase
      for (int i = 0; i < 8; i++) begin
        if (rel && i == m_cur) begin m_occ[i] = 0; m_cnt[i] = 0; end
        else if (bus.enter_valid && int'(bus.enter_slot) == i && !m_occ[i]) begin
          m_occ[i] = 1; m_cnt[i] = 0;
        end
        else if (tick && m_occ[i] && m_cnt[i] < 255) m_cnt[i]++;
      end
      m_lp = rel;
      if (rel) m_ls = m_cur;
      if (nst != 4) m_paid = 0;
      m_state = nst; m_cur = ncur; m_fee = nfee;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(bus.state), m_state);
      chk("occupied", int'(bus.occupied), int'(m_occ));
      chk("cursor", int'(bus.cursor), m_cur);
      chk("fee", int'(bus.fee), m_fee);
      chk("leave_pulse", int'(bus.leave_pulse), int'(m_lp));
      if (m_lp) chk("leave_slot", int'(bus.leave_slot), m_ls);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic btn(input logic [4:0] b);
    bus.bt_out = b; cyc(1);
    bus.bt_out = 5'd0; cyc(1);
  endtask

  task automatic enter(input int s);
    bus.enter_valid = 1'b1; bus.enter_slot = 3'(s); cyc(1);
    bus.enter_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc(1); rst = 1'b1;
  endtask

  localparam logic [4:0] MID = 5'b01000, LEFT = 5'b00010, RIGHT = 5'b00001;

  initial begin
    bus.bt_out = '0; bus.view = 3'd1; bus.key_out = '0;
    bus.enter_valid = 1'b0; bus.enter_slot = '0;
    cyc(2);
    chk_en = 1'b1;
    rst = 1'b1;
    chk("rst_state", int'(bus.state), 1);
    chk("rst_occ", int'(bus.occupied), 0);
    chk("rst_fee", int'(bus.fee), 0);
    chk("rst_pulse", int'(bus.leave_pulse), 0);

    btn(MID);
    chk("idle_empty_mid", int'(bus.state), 1);

    // Billing: three full units elapse before the fee is latched.
    enter(2);
    cyc(10);
    bus.bt_out = MID; cyc(1); bus.bt_out = 0; cyc(1);
    bus.bt_out = MID; cyc(1);
    chk("bill_state", int'(bus.state), 3);
    chk("bill_fee", int'(bus.fee), 15);
    bus.bt_out = 0; cyc(1);
    do_reset();
    chk("rst_bill_state", int'(bus.state), 1);
    chk("rst_bill_occ", int'(bus.occupied), 0);
    chk("rst_bill_pulse", int'(bus.leave_pulse), 0);

    // Cursor navigation over slots 1, 5, 6.
    enter(1); enter(5); enter(6);
    btn(MID);   chk("cur_first", int'(bus.cursor), 1);
    btn(RIGHT); chk("cur_r1", int'(bus.cursor), 5);
    btn(RIGHT); chk("cur_r2", int'(bus.cursor), 6);
    btn(RIGHT); chk("cur_wrap", int'(bus.cursor), 1);
    btn(LEFT);  chk("cur_left", int'(bus.cursor), 6);
    bus.key_out = 16'h0020; cyc(1); bus.key_out = 0;
    chk("cur_key5", int'(bus.cursor), 5);
    bus.key_out = 16'h0008; cyc(1); bus.key_out = 0;
    chk("cur_key3_empty", int'(bus.cursor), 5);
    btn(MID);   chk("bill5", int'(bus.state), 3);
    btn(RIGHT); chk("bill_right_ign", int'(bus.state), 3);
    btn(LEFT);  chk("bill_cancel", int'(bus.state), 2);
    btn(MID);   chk("bill5_again", int'(bus.state), 3);
    bus.bt_out = MID; cyc(1);
    chk("paid_pulse", int'(bus.leave_pulse), 1);
    chk("paid_slot", int'(bus.leave_slot), 5);
    chk("paid_occ", int'(bus.occupied), 8'h42);
    chk("paid_state", int'(bus.state), 4);
    bus.bt_out = 0; cyc(1);
    chk("pulse_once", int'(bus.leave_pulse), 0);
    cyc(6);
    chk("paid_hold", int'(bus.state), 4);
    cyc(1);
    chk("paid_timeout", int'(bus.state), 1);
    chk("paid_fee_clr", int'(bus.fee), 0);

    // Held mid acts once.
    bus.bt_out = MID; cyc(3); bus.bt_out = 0; cyc(1);
    chk("hold_once", int'(bus.state), 2);
    do_reset();

    // Saturation, re-entry ignored, gating, release-beats-entry, early PAID exit.
    enter(0);
    cyc(1040);
    enter(0);
    cyc(70);
    bus.view = 3'd2; bus.bt_out = MID; cyc(3);
    chk("gated_view", int'(bus.state), 1);
    bus.bt_out = 0; cyc(1); bus.view = 3'd1;
    btn(MID); btn(MID);
    chk("fee_sat", int'(bus.fee), 255);
    bus.bt_out = MID; bus.enter_valid = 1'b1; bus.enter_slot = 3'd0; cyc(1);
    bus.bt_out = 0; bus.enter_valid = 1'b0;
    chk("rel_wins_occ", int'(bus.occupied), 0);
    chk("rel_wins_slot", int'(bus.leave_slot), 0);
    cyc(1);
    btn(MID);
    chk("paid_mid_exit", int'(bus.state), 1);
    chk("paid_mid_fee", int'(bus.fee), 0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/car_leave_checkout.md
Name: car_leave_checkout

Overview:
- Exit-side counterpart of the entry selector: tracks which parking slots are occupied and how long each has been parked.
- At checkout the operator picks a slot, sees the fee, confirms, and the slot is released.
- Consumes entry events from the entry path, shares the button/keypad/view bus with it, and drives the fee and exit status to the display logic.

Parameters:
- N_SLOTS, 8, number of parking slots; fixed at 8 for this block.
- CLK_DIV, 100000000, clock cycles per billing unit (1 s at 100 MHz); benches use 4.
- RATE, 5, fee per started billing unit.
- PAID_CYCLES, 200000000, cycles the PAID state holds before returning to IDLE; benches use 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- bt_out  in  5  debounced buttons: [1] left, [0] right, [3] mid, others unused
- view  in  3  current UI page; this block acts only when view==3'd1
- key_out  in  16  one-hot keypad; [7:0] select slots 0..7, others unused
- enter_valid  in  1  one-cycle pulse: a car parked in enter_slot
- enter_slot  in  3  slot index for enter_valid
- occupied  out  8  per-slot occupancy
- cursor  out  3  currently selected slot
- fee  out  8  latched fee for the selected slot
- leave_pulse  out  1  one-cycle pulse when a slot is released
- leave_slot  out  3  slot released, valid with leave_pulse
- state  out  3  FSM state encoding

Behaviour:
- Reset (rst==0 at posedge clk):
  - occupied=0, cursor=0, fee=0, leave_pulse=0, leave_slot=0, state=IDLE.
  - All unit counters, the prescaler and the press latch are cleared.
  - Reset is honoured in any state, including mid-checkout.
- State encoding: IDLE=1, SELECT=2, BILL=3, PAID=4. Any other value goes to IDLE on the next cycle.
- Press latch:
  - A button action is taken only if the latch is clear; taking it sets the latch.
  - The latch clears in any cycle where left, right and mid are all 0.
  - Priority within one cycle: mid > left > right.
- Gating: when view!=1, buttons and keys are ignored and the FSM holds its state. The latch, timers and entry handling keep running.
- Prescaler and unit counters:
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - On wrap, each occupied slot's 8-bit unit counter increments, saturating at 255.
  - Counters of unoccupied slots stay 0.
- Entry:
  - enter_valid on an unoccupied slot sets occupied[enter_slot] and zeroes that slot's counter.
  - enter_valid on an occupied slot is ignored.
  - If an entry coincides with a release of the same slot, the release wins and the entry is ignored.
- IDLE:
  - mid with at least one slot occupied -> SELECT, cursor = lowest occupied index.
  - mid with no slot occupied -> stay in IDLE.
- SELECT:
  - right moves cursor to the next occupied slot in ascending order, wrapping 7->0.
  - left moves cursor to the previous occupied slot, wrapping 0->7.
  - With only one slot occupied, the cursor is unchanged.
  - key_out[i] with slot i occupied sets cursor=i. Keys for unoccupied slots are ignored. With several keys high, the lowest occupied index wins. Keys are level-sensitive and do not use the latch.
  - A key and a button in the same cycle: the button wins.
  - If the cursor slot becomes unoccupied, the FSM returns to IDLE.
  - mid -> BILL; fee latched as min(max(units,1)*RATE, 255), computed at 16 bits then saturated.
- BILL:
  - fee is frozen; the counter keeps running.
  - mid -> PAID: occupied[cursor] cleared, that slot's counter zeroed, leave_pulse=1 for exactly that cycle, leave_slot=cursor.
  - left -> SELECT (cancel); fee is retained.
  - right is ignored.
- PAID:
  - After PAID_CYCLES cycles in PAID, or on a mid press -> IDLE; fee cleared to 0 on leaving.
  - The PAID timer runs regardless of view.
- Latency: every transition and output change is registered and appears one clock after the triggering sampled input.

Test Plan:
- rst=0 for 2 cycles then 1 -> state=1, occupied=8'h00, fee=0, leave_pulse=0.
- CLK_DIV=4, view=1: enter slot 2; after 12 cycles press mid, mid -> state=3, fee=15 (3 units x 5).
- Slots 1, 5, 6 occupied; IDLE mid -> cursor=1. right, right, right -> cursor 5, 6, 1. left -> cursor=6. key_out[5]=1 -> cursor=5. key_out[3]=1 (slot 3 empty) -> cursor unchanged.
- In BILL on slot 5, press mid -> one-cycle leave_pulse, leave_slot=5, occupied=8'h42, state=4. After 8 cycles -> state=1, fee=0.
- Slot 0 occupied for more than 255 units -> fee=255. enter_valid for slot 0 while occupied -> counter not reset. view=2 with mid held -> state stays 1.
- Hold mid across two presses without releasing -> only one transition. rst=0 while in BILL -> state=1, occupied=0, no leave_pulse.
